prog_loader: RTL and testbench

Byte-serial program loader sitting directly upstream of the program memory's load port. It accepts bytes over a valid/ready handshake and packs each pair into one 12-bit instruction. It writes each instruction to consecutive program-memory addresses by driving the memory's enable, load-enable, load-address and instruction-in inputs. While a load is in progress it holds the CPU through busy; the top level ORs pm_e with the CPU's own fetch enable.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 145 ++++++++++++++
 tb/tb_prog_loader.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory load port bundle for prog_loader.
// The master side drives the byte stream and start; the slave side is the loader.
interface prog_loader_if;
   logic        start;
   logic [8:0]  len;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        pm_e;
   logic        pm_le;
   logic [7:0]  pm_load_addr;
   logic [11:0] pm_iin;
   logic        busy;
   logic        done;
   logic        err;
   logic [8:0]  count;

   modport master (
      output start, len, byte_in, byte_valid,
      input  byte_ready, pm_e, pm_le, pm_load_addr, pm_iin, busy, done, err, count
   );

   modport slave (
      input  start, len, byte_in, byte_valid,
      output byte_ready, pm_e, pm_le, pm_load_addr, pm_iin, busy, done, err, count
   );
endinterface

// File: rtl/prog_loader.sv
// Byte-serial program loader: packs byte pairs into 12-bit instructions and
// writes them to consecutive program-memory addresses, holding the CPU via busy.
module prog_loader #(
   parameter logic [7:0]  BASE_ADDR = 8'h00,
   parameter int unsigned TIMEOUT   = 1023
) (
   input logic            clk,
   input logic            rst,
   prog_loader_if.slave   bus
);

   // Idle counter only needs to hold 0..TIMEOUT-1 before the timeout fires.
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_LO,
      S_GET_HI,
      S_WRITE,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [8:0]    remaining_q, remaining_d;
   logic [7:0]    addr_q, addr_d;
   logic [8:0]    count_q, count_d;
   logic          err_q, err_d;
   logic [7:0]    lo_q, lo_d;
   logic [TW-1:0] idle_q, idle_d;
   logic [7:0]    load_addr_q, load_addr_d;
   logic [11:0]   iin_q, iin_d;

   logic          getting;
   logic          accept;
   logic          timeout_hit;
   logic [8:0]    len_clamped;

   assign getting     = (state_q == S_GET_LO) || (state_q == S_GET_HI);
   assign accept      = getting && bus.byte_valid;
   assign timeout_hit = (TIMEOUT != 0) && !accept && (idle_q == TW'(TIMEOUT - 1));
   assign len_clamped = (bus.len > 9'd256) ? 9'd256 : bus.len;

   // Next-state and datapath updates for the load sequence.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      count_d     = count_q;
      err_d       = err_q;
      lo_d        = lo_q;
      idle_d      = idle_q;
      load_addr_d = load_addr_q;
      iin_d       = iin_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               remaining_d = len_clamped;
               addr_d      = BASE_ADDR;
               count_d     = '0;
               err_d       = 1'b0;
               idle_d      = '0;
               state_d     = (len_clamped == 9'd0) ? S_DONE : S_GET_LO;
            end
         end
         S_GET_LO: begin
            if (accept) begin
               lo_d    = bus.byte_in;
               idle_d  = '0;
               state_d = S_GET_HI;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         S_GET_HI: begin
            if (accept) begin
               // Word is written even when the unused high nibble is nonzero.
               iin_d       = {bus.byte_in[3:0], lo_q};
               load_addr_d = addr_q;
               if (bus.byte_in[7:4] != 4'h0) err_d = 1'b1;
               idle_d      = '0;
               state_d     = S_WRITE;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         S_WRITE: begin
            addr_d      = addr_q + 8'd1;
            count_d     = (count_q == 9'd256) ? count_q : count_q + 9'd1;
            remaining_d = remaining_q - 9'd1;
            state_d     = (remaining_q == 9'd1) ? S_DONE : S_GET_LO;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         lo_q        <= '0;
         idle_q      <= '0;
         load_addr_q <= '0;
         iin_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         err_q       <= err_d;
         lo_q        <= lo_d;
         idle_q      <= idle_d;
         load_addr_q <= load_addr_d;
         iin_q       <= iin_d;
      end
   end

   assign bus.byte_ready   = getting;
   assign bus.busy         = getting || (state_q == S_WRITE);
   assign bus.pm_e         = (state_q == S_WRITE);
   assign bus.pm_le        = (state_q == S_WRITE);
   assign bus.pm_load_addr = load_addr_q;
   assign bus.pm_iin       = iin_q;
   assign bus.done         = (state_q == S_DONE);
   assign bus.err          = err_q;
   assign bus.count        = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: two instances (base 00/timeout 1023 and
// base FE/timeout 8) share one stimulus stream; each has its own behavioural model.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [8:0] len;
   logic [7:0] byte_in;
   logic       byte_valid;

   always #5 clk = ~clk;

   prog_loader_if if_a ();
   prog_loader_if if_b ();

   assign if_a.start = start;  assign if_b.start = start;
   assign if_a.len = len;      assign if_b.len = len;
   assign if_a.byte_in = byte_in;        assign if_b.byte_in = byte_in;
   assign if_a.byte_valid = byte_valid;  assign if_b.byte_valid = byte_valid;

   prog_loader #(.BASE_ADDR(8'h00), .TIMEOUT(1023)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   prog_loader #(.BASE_ADDR(8'hFE), .TIMEOUT(8))    u_b (.clk(clk), .rst(rst), .bus(if_b));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_on = 1'b0;

   // Transaction-level view of a loader: what it is doing and what it last drove.
   typedef struct {
      bit active;     // waiting for bytes
      bit got_lo;     // low byte of the current word held
      bit writing;    // a word is on the memory port this cycle
      bit done;       // done pulse this cycle
      int left;       // words still to write
      int addr;       // next address
      int count;
      bit err;
      int idle;       // consecutive cycles without an accepted byte
      int lo;
      int last_addr;
      int last_word;
   } model_t;

   model_t m[2];
   int base_addr[2] = '{0, 254};
   int tmo[2] = '{1023, 8};

   typedef struct { int addr; int word; } wr_t;
   wr_t wlog_a[$];
   wr_t wlog_b[$];
   int done_cnt_a, done_cnt_b, done_cyc_a, start_cyc;
   bit busy_seen_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Advance one loader model by one clock using the inputs present at the edge.
   task automatic model_step(input int d);
      model_t s;
      bit was_idle;
      int n;
      s = m[d];
      if (rst) begin
         s = '{default: 0};
      end else begin
         was_idle = !s.active && !s.writing && !s.done;
         s.done = 1'b0;
         if (s.writing) begin
            s.writing = 1'b0;
            s.count = (s.count >= 256) ? 256 : s.count + 1;
            s.left--;
            s.addr = (s.addr + 1) % 256;
            if (s.left == 0) s.done = 1'b1;
            else s.active = 1'b1;
         end else if (s.active) begin
            if (byte_valid) begin
               s.idle = 0;
               if (!s.got_lo) begin
                  s.lo = int'(byte_in);
                  s.got_lo = 1'b1;
               end else begin
                  s.got_lo = 1'b0;
                  s.active = 1'b0;
                  s.writing = 1'b1;
                  s.last_addr = s.addr;
                  s.last_word = ((int'(byte_in) & 15) << 8) | s.lo;
                  if ((int'(byte_in) >> 4) != 0) s.err = 1'b1;
               end
            end else begin
               s.idle++;
               if (tmo[d] != 0 && s.idle >= tmo[d]) begin
                  s.active = 1'b0;
                  s.got_lo = 1'b0;
                  s.err = 1'b1;
               end
            end
         end else if (was_idle && start) begin
            n = (int'(len) > 256) ? 256 : int'(len);
            s.left = n;
            s.addr = base_addr[d];
            s.count = 0;
            s.err = 1'b0;
            s.idle = 0;
            s.got_lo = 1'b0;
            if (n == 0) s.done = 1'b1;
            else s.active = 1'b1;
         end
      end
      m[d] = s;
   endtask

   task automatic cmp(input int d, input logic br, input logic bsy, input logic pe,
                      input logic ple, input logic [7:0] la, input logic [11:0] iin,
                      input logic dn, input logic er, input logic [8:0] cnt);
      model_t s;
      string p;
      s = m[d];
      p = (d == 0) ? "a" : "b";
      check({p, "_byte_ready"}, 32'(br), 32'(s.active));
      check({p, "_busy"}, 32'(bsy), 32'(s.active | s.writing));
      check({p, "_pm_e"}, 32'(pe), 32'(s.writing));
      check({p, "_pm_le"}, 32'(ple), 32'(s.writing));
      check({p, "_pm_load_addr"}, 32'(la), s.last_addr);
      check({p, "_pm_iin"}, 32'(iin), s.last_word);
      check({p, "_done"}, 32'(dn), 32'(s.done));
      check({p, "_err"}, 32'(er), 32'(s.err));
      check({p, "_count"}, 32'(cnt), s.count);
   endtask

   // Per-cycle compare of both instances against their models, plus write/done logging.
   always @(negedge clk) begin
      if (model_on) begin
         cmp(0, if_a.byte_ready, if_a.busy, if_a.pm_e, if_a.pm_le, if_a.pm_load_addr,
             if_a.pm_iin, if_a.done, if_a.err, if_a.count);
         cmp(1, if_b.byte_ready, if_b.busy, if_b.pm_e, if_b.pm_le, if_b.pm_load_addr,
             if_b.pm_iin, if_b.done, if_b.err, if_b.count);
         if (if_a.pm_le === 1'b1) wlog_a.push_back('{int'(if_a.pm_load_addr), int'(if_a.pm_iin)});
         if (if_b.pm_le === 1'b1) wlog_b.push_back('{int'(if_b.pm_load_addr), int'(if_b.pm_iin)});
         if (if_a.done === 1'b1) begin done_cnt_a++; done_cyc_a = cyc; end
         if (if_b.done === 1'b1) done_cnt_b++;
         if (if_a.busy === 1'b1) busy_seen_a = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      model_on = 1'b1;
      cyc++;
      #1;
   endtask

   task automatic clr();
      wlog_a.delete();
      wlog_b.delete();
      done_cnt_a = 0;
      done_cnt_b = 0;
      done_cyc_a = -1;
      busy_seen_a = 1'b0;
   endtask

   task automatic do_start(input int n);
      len = 9'(n);
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      acc = 1'b0;
      byte_in = b;
      byte_valid = 1'b1;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = m[0].active;
         tick();
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_byte_bound: byte %0h not taken in 64 cycles", b);
      end
   endtask

   task automatic wait_quiet(input int bound);
      bit q;
      q = 1'b0;
      byte_valid = 1'b0;
      for (int i = 0; i < bound && !q; i++) begin
         q = !m[0].active && !m[0].writing && !m[0].done &&
             !m[1].active && !m[1].writing && !m[1].done;
         if (!q) tick();
      end
      if (!q) begin
         checks++;
         errors++;
         $display("FAIL wait_quiet_bound: loaders still busy after %0d cycles", bound);
      end
   endtask

   initial begin
      int k;
      int gap;
      rst = 1'b1; start = 1'b0; len = '0; byte_in = '0; byte_valid = 1'b0;
      clr();
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_busy", 32'(if_a.busy), 0);
      check("reset_count", 32'(if_a.count), 0);
      check("reset_iin", 32'(if_a.pm_iin), 0);

      // Two back-to-back words.
      clr();
      do_start(2);
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12); send_byte(8'h0F);
      wait_quiet(50);
      check("t1_nwrites", wlog_a.size(), 2);
      check("t1_addr0", wlog_a[0].addr, 32'h00);
      check("t1_word0", wlog_a[0].word, 32'h3A5);
      check("t1_addr1", wlog_a[1].addr, 32'h01);
      check("t1_word1", wlog_a[1].word, 32'hF12);
      check("t1_done_latency", done_cyc_a - start_cyc, 7);
      check("t1_count", 32'(if_a.count), 2);
      check("t1_err", 32'(if_a.err), 0);
      check("t1_b_addr0", wlog_b[0].addr, 32'hFE);
      check("t1_b_addr1", wlog_b[1].addr, 32'hFF);

      // Nonzero high nibble: word still written, err set, done still pulses.
      clr();
      do_start(1);
      send_byte(8'h3C); send_byte(8'hF7);
      wait_quiet(50);
      check("t2_word", wlog_a[0].word, 32'h73C);
      check("t2_err", 32'(if_a.err), 1);
      check("t2_done", done_cnt_a, 1);

      // Address wrap on the FE-based instance.
      clr();
      do_start(3);
      for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
      wait_quiet(50);
      check("t3_nwrites", wlog_b.size(), 3);
      check("t3_addr0", wlog_b[0].addr, 32'hFE);
      check("t3_addr1", wlog_b[1].addr, 32'hFF);
      check("t3_addr2", wlog_b[2].addr, 32'h00);
      check("t3_word2", wlog_b[2].word, 32'h605);

      // Zero-length load.
      clr();
      do_start(0);
      wait_quiet(10);
      check("t4_nwrites", wlog_a.size(), 0);
      check("t4_done_latency", done_cyc_a - start_cyc, 1);
      check("t4_busy_seen", 32'(busy_seen_a), 0);

      // Timeout after three of four bytes.
      clr();
      do_start(2);
      send_byte(8'h11); send_byte(8'h02); send_byte(8'h33);
      byte_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("t5_b_busy_before", 32'(if_b.busy), 1);
      tick();
      check("t5_b_busy_after", 32'(if_b.busy), 0);
      check("t5_b_err", 32'(if_b.err), 1);
      check("t5_b_nwrites", wlog_b.size(), 1);
      check("t5_b_done", done_cnt_b, 0);
      k = 8;
      while (if_a.busy === 1'b1 && k < 1100) begin tick(); k++; end
      check("t5_a_timeout_cycles", k, 1023);
      check("t5_a_err", 32'(if_a.err), 1);
      check("t5_a_done", done_cnt_a, 0);
      wait_quiet(10);

      // Reset while waiting for the high byte.
      clr();
      do_start(1);
      send_byte(8'h99);
      byte_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_byte_ready", 32'(if_a.byte_ready), 0);
      check("t6_busy", 32'(if_a.busy), 0);
      check("t6_pm_le", 32'(if_a.pm_le), 0);
      check("t6_pm_e", 32'(if_a.pm_e), 0);
      check("t6_done", 32'(if_a.done), 0);
      check("t6_err", 32'(if_a.err), 0);
      check("t6_count", 32'(if_a.count), 0);
      check("t6_addr", 32'(if_a.pm_load_addr), 0);
      check("t6_iin", 32'(if_a.pm_iin), 0);
      do_start(1);
      send_byte(8'h55); send_byte(8'h0A);
      wait_quiet(50);
      check("t6_reload_word", wlog_a[0].word, 32'hA55);
      check("t6_reload_addr", wlog_a[0].addr, 32'h00);
      check("t6_reload_done", done_cnt_a, 1);

      // Randomized traffic: starts at any time, gaps that trip the short timeout, rare resets.
      gap = 0;
      for (int i = 0; i < 6000; i++) begin
         start = ($urandom % 8 == 0);
         k = $urandom % 32;
         len = (k == 0) ? 9'd300 : (k == 1) ? 9'd0 : 9'($urandom_range(1, 6));
         byte_in = 8'($urandom);
         if (gap > 0) begin
            byte_valid = 1'b0;
            gap--;
         end else if ($urandom % 25 == 0) begin
            byte_valid = 1'b0;
            gap = $urandom_range(5, 12);
         end else begin
            byte_valid = ($urandom % 10 < 7);
         end
         rst = ($urandom % 700 == 0);
         tick();
      end
      start = 1'b0;
      byte_valid = 1'b0;
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
